mips_multicycle_ctrl: RTL
=========================

// Module: mips_multicycle_ctrl
// PURPOSE
//  Multi-cycle sequencer for the 32-bit MIPS core. It replaces single-cycle decode with a Moore FSM.
//  It issues per-state datapath controls and handshakes with the memory port (mem_ready) and the
//  mult/div unit (md_start/md_done). It sits between the instruction register and the datapath muxes/ALU.
// PARAMETERS
//  MEM_TMO   16  cycles to wait for mem_ready before flagging bus_err and aborting to FETCH
//  MD_TMO    40  cycles to wait for md_done before flagging bus_err and aborting to FETCH
// PORTS
//  clk        in   1  rising-edge clock
//  rst_n      in   1  asynchronous active-low reset
//  opCode     in   6  IR[31:26], valid from DECODE onward
//  funct      in   6  IR[5:0]
//  mem_ready  in   1  memory completes current read/write this cycle
//  md_done    in   1  mult/div unit result ready (1-cycle pulse)
//  zero       in   1  ALU zero flag (for beq)
//  PCWrite    out  1  unconditional PC load
//  PCWriteCond out 1  PC load if zero
//  IorD       out  1  0=PC addresses memory, 1=ALUOut
//  IRWrite    out  1  load instruction register
//  MemRead    out  1  memory read request
//  MemWrite   out  1  memory write request
//  MemtoReg   out  1  0=ALUOut, 1=MDR to register file
//  RegDst     out  1  0=rt, 1=rd
//  RegWrite   out  1  register file write enable
//  ALUSrcA    out  1  0=PC, 1=regA
//  ALUSrcB    out  2  00=regB 01=4 10=signext imm 11=signext imm<<2
//  ALUOp      out  2  00=add 01=sub 10=addi 11=funct-decoded (R-type)
//  PCSource   out  2  00=ALU 01=ALUOut 10=jump target
//  md_start   out  1  1-cycle start pulse to mult/div unit
//  illegal    out  1  1-cycle pulse: unsupported opcode seen in DECODE
//  bus_err    out  1  1-cycle pulse: MEM_TMO/MD_TMO expired
//  state_o    out  4  current state encoding (debug)
// BEHAVIOUR
//  Reset: state=FETCH(0); all outputs 0 except outputs that FETCH drives combinationally; timeout counter=0.
//  Outputs are a combinational function of state only (Moore); illegal and bus_err are registered pulses.
//  States/encodings: FETCH0 DECODE1 MEMADR2 MEMRD3 MEMWB4 MEMWR5 EXEC6 RWB7 BRANCH8 JUMP9 ADDIEX10 IWB11 MDSTART12 MDWAIT13.
//  FETCH: MemRead=1 IorD=0 IRWrite=mem_ready ALUSrcA=0 ALUSrcB=01 ALUOp=00 PCSource=00 PCWrite=mem_ready.
//    Hold until mem_ready, then go to DECODE.
//  DECODE: ALUSrcA=0 ALUSrcB=11 ALUOp=00 (branch target). Decode by opCode:
//    100011/101011 -> MEMADR; 000000 with funct 011000/011010 -> MDSTART; other 000000 -> EXEC;
//    000100 -> BRANCH; 000010 -> JUMP; 001000 -> ADDIEX; else illegal pulse and go to FETCH.
//  MEMADR: ALUSrcA=1 ALUSrcB=10 ALUOp=00; go to MEMRD if lw, else MEMWR.
//  MEMRD: MemRead=1 IorD=1; hold until mem_ready, then go to MEMWB.
//  MEMWB: RegDst=0 MemtoReg=1 RegWrite=1; go to FETCH.
//  MEMWR: MemWrite=1 IorD=1; hold until mem_ready, then go to FETCH.
//  EXEC: ALUSrcA=1 ALUSrcB=00 ALUOp=11; go to RWB.
//  RWB: RegDst=1 MemtoReg=0 RegWrite=1; go to FETCH.
//  BRANCH: ALUSrcA=1 ALUSrcB=00 ALUOp=01 PCWriteCond=1 PCSource=01; go to FETCH.
//  JUMP: PCWrite=1 PCSource=10; go to FETCH.
//  ADDIEX: ALUSrcA=1 ALUSrcB=10 ALUOp=10; go to IWB.
//  IWB: RegDst=0 MemtoReg=0 RegWrite=1; go to FETCH.
//  MDSTART: md_start=1, ALUSrcA=1 ALUSrcB=00; go to MDWAIT.
//  MDWAIT: hold until md_done, then go to FETCH. No RegWrite; HI/LO are written by the mult/div unit.
//  Timeout counter: cleared on every state change; increments while in FETCH/MEMRD/MEMWR/MDWAIT.
//    Reaching MEM_TMO-1 (memory states) or MD_TMO-1 (MDWAIT) without the handshake -> bus_err pulse,
//    then go to FETCH. The counter saturates and never wraps.
//  A handshake on the same cycle as the timeout limit: handshake wins, no bus_err.
//  md_done/mem_ready outside a waiting state: ignored.
//  Async reset mid-instruction: FSM returns to FETCH immediately; write strobes drop without waiting for a clock edge.
//  Cycle counts with zero wait: R/addi 4, lw 5, sw 4, beq 3, j 3, mult/div 4 + unit latency.
// TESTING
//  Reset asserted mid-MEMWR -> MemWrite=0 and state_o=0 immediately; after release FETCH asserts MemRead=1.
//  add (000000/100000), mem_ready=1 always -> states 0,1,6,7,0; RegWrite=1 only in cycle 4 with RegDst=1.
//  lw with mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles; then MEMWB with MemtoReg=1 RegWrite=1.
//  beq -> BRANCH with PCWriteCond=1 PCSource=01 ALUOp=01; j -> JUMP with PCWrite=1 PCSource=10; each 3 cycles.
//  mult (funct 011000), md_done after 10 cycles -> md_start pulses once; 10-cycle MDWAIT; no RegWrite.
//  Opcode 111111 -> illegal pulses 1 cycle, FETCH next; mem_ready never high in MEMWR -> bus_err after MEM_TMO=16 cycles.

Source files
------------

// File: rtl/mips_multicycle_ctrl_if.sv
// Control bus between the multi-cycle MIPS sequencer and the rest of the core.
//
// Carries the instruction fields and handshakes that come into the sequencer,
// the datapath controls it drives out, and the debug view of its state.
//
// Handshake rules:
//   mem_ready : the memory finishes the current read/write in the cycle it is
//               high. The sequencer acts on it only in FETCH, MEMRD and MEMWR
//               and ignores it in every other state.
//   md_start  : one-cycle pulse that starts the mult/div unit.
//   md_done   : one-cycle pulse from the mult/div unit. The sequencer acts on
//               it only in MDWAIT and ignores it in every other state.
//   illegal, bus_err : one-cycle registered pulses.
//
// Modports:
//   master : the sequencer (receives IR fields and handshakes, drives controls)
//   slave  : the instruction register / datapath / memory / mult-div side
interface mips_multicycle_ctrl_if;
  logic [5:0] opCode;
  logic [5:0] funct;
  logic       mem_ready;
  logic       md_done;
  logic       zero;

  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       IRWrite;
  logic       MemRead;
  logic       MemWrite;
  logic       MemtoReg;
  logic       RegDst;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] PCSource;
  logic       md_start;
  logic       illegal;
  logic       bus_err;
  logic [3:0] state_o;

  modport master (
    input  opCode, funct, mem_ready, md_done, zero,
    output PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           md_start, illegal, bus_err, state_o
  );

  modport slave (
    output opCode, funct, mem_ready, md_done, zero,
    input  PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           md_start, illegal, bus_err, state_o
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle Moore sequencer for the 32-bit MIPS core.
//
// It steps each instruction through FETCH / DECODE / execute / writeback
// states and drives the datapath mux selects, ALU op and write strobes from
// the current state. It waits on mem_ready for memory accesses and on md_done
// for mult/div. If a wait runs too long, it raises bus_err and aborts to FETCH.
//
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : mips_multicycle_ctrl_if.master (IR fields, handshakes,
//           datapath controls, illegal/bus_err pulses, state_o debug)
//
// Parameters:
//   MEM_TMO : number of cycles to wait for mem_ready before bus_err
//   MD_TMO  : number of cycles to wait for md_done before bus_err
module mips_multicycle_ctrl #(
  parameter int MEM_TMO = 16,
  parameter int MD_TMO  = 40
) (
  input logic                   clk,
  input logic                   rst_n,
  mips_multicycle_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RWB     = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_ADDIEX  = 4'd10,
    S_IWB     = 4'd11,
    S_MDSTART = 4'd12,
    S_MDWAIT  = 4'd13
  } state_t;

  localparam int TMO_MAX = (MD_TMO > MEM_TMO) ? MD_TMO : MEM_TMO;
  localparam int CW      = $clog2(TMO_MAX) + 1;
  localparam logic [CW-1:0] MEM_LIM = CW'(MEM_TMO - 1);
  localparam logic [CW-1:0] MD_LIM  = CW'(MD_TMO - 1);

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] tmo_cnt;
  logic          tmo_hit;
  logic          bad_op;
  logic          illegal_q;
  logic          bus_err_q;

  logic is_lw, is_sw, is_rtype, is_md, is_beq, is_j, is_addi;

  assign is_lw    = (bus.opCode == 6'b100011);
  assign is_sw    = (bus.opCode == 6'b101011);
  assign is_rtype = (bus.opCode == 6'b000000);
  assign is_md    = is_rtype && ((bus.funct == 6'b011000) || (bus.funct == 6'b011010));
  assign is_beq   = (bus.opCode == 6'b000100);
  assign is_j     = (bus.opCode == 6'b000010);
  assign is_addi  = (bus.opCode == 6'b001000);

  // Next-state logic. In the wait states the handshake is tested before the
  // limit, so a handshake in the same cycle as the limit completes normally.
  always_comb begin
    state_next = state;
    tmo_hit    = 1'b0;
    bad_op     = 1'b0;
    case (state)
      S_FETCH: begin
        if (bus.mem_ready)           state_next = S_DECODE;
        else if (tmo_cnt >= MEM_LIM) tmo_hit    = 1'b1;
      end
      S_DECODE: begin
        if (is_lw || is_sw)  state_next = S_MEMADR;
        else if (is_md)      state_next = S_MDSTART;
        else if (is_rtype)   state_next = S_EXEC;
        else if (is_beq)     state_next = S_BRANCH;
        else if (is_j)       state_next = S_JUMP;
        else if (is_addi)    state_next = S_ADDIEX;
        else begin
          bad_op     = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_MEMADR: state_next = is_lw ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        if (bus.mem_ready)           state_next = S_MEMWB;
        else if (tmo_cnt >= MEM_LIM) tmo_hit    = 1'b1;
      end
      S_MEMWB: state_next = S_FETCH;
      S_MEMWR: begin
        if (bus.mem_ready)           state_next = S_FETCH;
        else if (tmo_cnt >= MEM_LIM) tmo_hit    = 1'b1;
      end
      S_EXEC:    state_next = S_RWB;
      S_RWB:     state_next = S_FETCH;
      S_BRANCH:  state_next = S_FETCH;
      S_JUMP:    state_next = S_FETCH;
      S_ADDIEX:  state_next = S_IWB;
      S_IWB:     state_next = S_FETCH;
      S_MDSTART: state_next = S_MDWAIT;
      S_MDWAIT: begin
        if (bus.md_done)            state_next = S_FETCH;
        else if (tmo_cnt >= MD_LIM) tmo_hit    = 1'b1;
      end
      default:   state_next = S_FETCH;
    endcase
    if (tmo_hit) state_next = S_FETCH;
  end

  // Only the wait states keep the same state across a clock edge, so the
  // counter advances only while waiting. It is cleared on every transition
  // and on a timeout abort. An abort from FETCH stays in FETCH, so the abort
  // must clear the counter too, or it would time out again on the next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_FETCH;
      tmo_cnt   <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state     <= state_next;
      illegal_q <= bad_op;
      bus_err_q <= tmo_hit;
      if ((state_next != state) || tmo_hit) tmo_cnt <= '0;
      else if (tmo_cnt != '1)               tmo_cnt <= tmo_cnt + CW'(1);
    end
  end

  // Moore outputs, decoded from the state alone. The exception is FETCH:
  // there, IRWrite and PCWrite follow mem_ready so that the instruction and
  // PC+4 are captured in the cycle the read completes.
  // zero is not used here: the datapath gates PCWriteCond with it.
  always_comb begin
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.IorD        = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.MemtoReg    = 1'b0;
    bus.RegDst      = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.ALUSrcA     = 1'b0;
    bus.ALUSrcB     = 2'b00;
    bus.ALUOp       = 2'b00;
    bus.PCSource    = 2'b00;
    bus.md_start    = 1'b0;
    case (state)
      S_FETCH: begin
        bus.MemRead = 1'b1;
        bus.ALUSrcB = 2'b01;
        bus.IRWrite = bus.mem_ready;
        bus.PCWrite = bus.mem_ready;
      end
      S_DECODE:  bus.ALUSrcB = 2'b11;
      S_MEMADR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        bus.MemRead = 1'b1;
        bus.IorD    = 1'b1;
      end
      S_MEMWB: begin
        bus.MemtoReg = 1'b1;
        bus.RegWrite = 1'b1;
      end
      S_MEMWR: begin
        bus.MemWrite = 1'b1;
        bus.IorD     = 1'b1;
      end
      S_EXEC: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUOp   = 2'b11;
      end
      S_RWB: begin
        bus.RegDst   = 1'b1;
        bus.RegWrite = 1'b1;
      end
      S_BRANCH: begin
        bus.ALUSrcA     = 1'b1;
        bus.ALUOp       = 2'b01;
        bus.PCWriteCond = 1'b1;
        bus.PCSource    = 2'b01;
      end
      S_JUMP: begin
        bus.PCWrite  = 1'b1;
        bus.PCSource = 2'b10;
      end
      S_ADDIEX: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        bus.ALUOp   = 2'b10;
      end
      S_IWB:     bus.RegWrite = 1'b1;
      S_MDSTART: begin
        bus.md_start = 1'b1;
        bus.ALUSrcA  = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.illegal = illegal_q;
  assign bus.bus_err = bus_err_q;
  assign bus.state_o = state;

endmodule
